// File: rtl/conv3d_job_scheduler_if.sv
// Requester/engine handshake bundle for the 3D convolution job scheduler.
// The scheduler takes the slave view; requesters and engine model take the master view.
interface conv3d_job_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [2*NUM_REQ-1:0] req_filter;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   job_done;
    logic [NUM_REQ-1:0]   job_err;
    logic                 eng_start;
    logic [1:0]           eng_filter;
    logic                 eng_done;
    logic                 busy;
    logic [15:0]          jobs_completed;

    modport master (
        output req, req_filter, eng_done,
        input  gnt, job_done, job_err, eng_start, eng_filter, busy, jobs_completed
    );

    modport slave (
        input  req, req_filter, eng_done,
        output gnt, job_done, job_err, eng_start, eng_filter, busy, jobs_completed
    );
endinterface

// File: rtl/conv3d_job_scheduler.sv
// Round-robin scheduler granting one shared 3D convolution engine to NUM_REQ requesters,
// with bad-filter rejection and a WAIT timeout. All outputs are registered.
module conv3d_job_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned NUM_FILTERS = 3,
    parameter int unsigned TIMEOUT     = 1024
) (
    input logic                   clk,
    input logic                   reset_n,
    conv3d_job_scheduler_if.slave bus
);
    localparam int unsigned     IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
    localparam logic [IdxW-1:0] LastRst = IdxW'(NUM_REQ - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT);

    typedef enum logic [2:0] {StIdle, StLaunch, StWait, StResp, StReject} state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic                eng_start_q, eng_start_d;
    logic [1:0]          eng_filter_q, eng_filter_d;
    logic                busy_q, busy_d;
    logic [15:0]         jobs_q, jobs_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     last_q, last_d;
    logic [IdxW-1:0]     win_q, win_d;

    logic [IdxW-1:0]     cand;
    logic [IdxW-1:0]     pick;
    logic                found;
    logic [NUM_REQ-1:0]  pick_oh;
    logic [1:0]          pick_filter;

    // Search starts one past the last job owner so every requester gets a turn.
    always_comb begin
        cand  = '0;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = IdxW'((int'(last_q) + k) % int'(NUM_REQ));
            if (!found && bus.req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        pick_oh       = '0;
        pick_oh[pick] = 1'b1;
        pick_filter   = bus.req_filter[{pick, 1'b0} +: 2];
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        done_d       = '0;
        err_d        = '0;
        eng_start_d  = 1'b0;
        eng_filter_d = eng_filter_q;
        busy_d       = busy_q;
        jobs_d       = jobs_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        win_d        = win_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    win_d  = pick;
                    gnt_d  = pick_oh;
                    busy_d = 1'b1;
                    if (32'(pick_filter) < NUM_FILTERS) begin
                        state_d      = StLaunch;
                        eng_start_d  = 1'b1;
                        eng_filter_d = pick_filter;
                    end else begin
                        state_d = StReject;
                        err_d   = pick_oh;
                    end
                end
            end
            StLaunch: begin
                state_d = StWait;
                cnt_d   = '0;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                // A completion on the last allowed cycle still counts as success.
                if (bus.eng_done) begin
                    state_d = StResp;
                    done_d  = gnt_q;
                    if (jobs_q != 16'hFFFF) begin
                        jobs_d = jobs_q + 16'd1;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d = StResp;
                    err_d   = gnt_q;
                end
            end
            StResp, StReject: begin
                state_d = StIdle;
                gnt_d   = '0;
                busy_d  = 1'b0;
                last_d  = win_q;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            gnt_q        <= '0;
            done_q       <= '0;
            err_q        <= '0;
            eng_start_q  <= 1'b0;
            eng_filter_q <= 2'd0;
            busy_q       <= 1'b0;
            jobs_q       <= 16'd0;
            cnt_q        <= '0;
            last_q       <= LastRst;
            win_q        <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
            eng_start_q  <= eng_start_d;
            eng_filter_q <= eng_filter_d;
            busy_q       <= busy_d;
            jobs_q       <= jobs_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            win_q        <= win_d;
        end
    end

    assign bus.gnt            = gnt_q;
    assign bus.job_done       = done_q;
    assign bus.job_err        = err_q;
    assign bus.eng_start      = eng_start_q;
    assign bus.eng_filter     = eng_filter_q;
    assign bus.busy           = busy_q;
    assign bus.jobs_completed = jobs_q;
endmodule

// File: tb/tb_conv3d_job_scheduler.sv
// Bench for conv3d_job_scheduler: directed scenarios with literal expectations, then
// randomized traffic checked each cycle against a job-timeline reference model.
module tb_conv3d_job_scheduler;
    localparam int NR = 4;
    localparam int NF = 3;
    localparam int T  = 12;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    conv3d_job_scheduler_if #(.NUM_REQ(NR)) bus ();

    conv3d_job_scheduler #(
        .NUM_REQ    (NR),
        .NUM_FILTERS(NF),
        .TIMEOUT    (T)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one job at a time, described by owner, filter and age since grant.
    // A good job launches at age 0, waits from age 1, and must respond by the cycle after
    // age T+1 (response T+2 cycles after launch).
    bit   m_active, m_good, m_resp, m_ok;
    int   m_owner, m_last, m_age, m_jobs;
    logic [1:0] m_filter;

    task automatic model_reset();
        m_active = 0;
        m_resp   = 0;
        m_last   = NR - 1;
        m_jobs   = 0;
    endtask

    task automatic model_step();
        if (!m_active) begin
            for (int k = 1; k <= NR; k++) begin
                int i;
                i = (m_last + k) % NR;
                if (!m_active && bus.req[i]) begin
                    m_active = 1;
                    m_owner  = i;
                    m_filter = bus.req_filter[2*i +: 2];
                    m_good   = (int'(m_filter) < NF);
                    m_age    = 0;
                    m_resp   = 0;
                end
            end
        end else if (!m_good || m_resp) begin
            m_active = 0;
            m_resp   = 0;
            m_last   = m_owner;
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (bus.eng_done) begin
            m_resp = 1;
            m_ok   = 1;
            if (m_jobs < 16'hFFFF) m_jobs++;
        end else if (m_age == T + 1) begin
            m_resp = 1;
            m_ok   = 0;
        end else begin
            m_age++;
        end
    endtask

    always @(negedge clk) begin
        logic [NR-1:0] oh, e_done, e_err;
        logic e_start;
        if (!reset_n) model_reset();
        oh      = m_active ? (NR'(1) << m_owner) : '0;
        e_start = m_active && m_good && !m_resp && m_age == 0;
        e_done  = (m_active && m_resp && m_ok) ? oh : '0;
        e_err   = (m_active && ((!m_good) || (m_resp && !m_ok))) ? oh : '0;
        chk("gnt", bus.gnt, oh);
        chk("busy", bus.busy, m_active);
        chk("eng_start", bus.eng_start, e_start);
        chk("job_done", bus.job_done, e_done);
        chk("job_err", bus.job_err, e_err);
        chk("jobs_completed", bus.jobs_completed, m_jobs);
        if (m_active && m_good) chk("eng_filter", bus.eng_filter, m_filter);
        if (reset_n) model_step();
    end

    initial begin
        int g[5];
        int exp_seq[5] = '{1, 2, 4, 8, 1};
        int n, cyc, p;
        logic [1:0] f[NR];

        reset_n        = 1'b0;
        bus.req        = '0;
        bus.req_filter = '0;
        bus.eng_done   = 1'b0;
        repeat (2) tick();
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_jobs", bus.jobs_completed, 0);
        chk("rst_filter", bus.eng_filter, 0);

        // Single job, filter 2, engine finishes 5 cycles after start.
        reset_n        = 1'b1;
        bus.req        = 4'b0001;
        bus.req_filter = 8'b00_00_00_10;
        tick();
        chk("s1_gnt", bus.gnt, 4'b0001);
        chk("s1_start", bus.eng_start, 1);
        chk("s1_filter", bus.eng_filter, 2);
        bus.req = '0;
        repeat (5) tick();
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        chk("s1_done", bus.job_done, 4'b0001);
        chk("s1_err", bus.job_err, 0);
        chk("s1_gnt_resp", bus.gnt, 4'b0001);
        chk("s1_jobs", bus.jobs_completed, 1);
        tick();
        chk("s1_idle", bus.busy, 0);

        // All requesting with instant completion: rotation 0,1,2,3,0 after reset.
        reset_n = 1'b0;
        tick();
        reset_n        = 1'b1;
        bus.req        = 4'b1111;
        bus.req_filter = 8'h00;
        bus.eng_done   = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            tick();
            if (bus.eng_start) begin
                g[n] = int'(bus.gnt);
                n++;
                if (n == 5) bus.req = '0;
            end
        end
        chk("s2_count", n, 5);
        for (int i = 0; i < 5; i++) chk("s2_order", g[i], exp_seq[i]);
        repeat (4) tick();
        bus.eng_done = 1'b0;
        chk("s2_jobs", bus.jobs_completed, 5);

        // Bad filter index is rejected without starting the engine.
        bus.req        = 4'b0100;
        bus.req_filter = 8'b00_11_00_00;
        tick();
        chk("s3_gnt", bus.gnt, 4'b0100);
        chk("s3_err", bus.job_err, 4'b0100);
        chk("s3_start", bus.eng_start, 0);
        bus.req = '0;
        tick();
        chk("s3_idle", bus.busy, 0);

        // Engine never answers: error T+2 cycles after launch.
        bus.req        = 4'b0001;
        bus.req_filter = 8'h01;
        tick();
        chk("s4_start", bus.eng_start, 1);
        bus.req = '0;
        cyc = 0;
        for (int c = 0; c < T + 10; c++) begin
            tick();
            cyc++;
            if (bus.job_err != 0) break;
        end
        chk("s4_latency", cyc, T + 2);
        chk("s4_err", bus.job_err, 4'b0001);
        chk("s4_done", bus.job_done, 0);
        chk("s4_jobs", bus.jobs_completed, 5);
        tick();

        // Completion on the final timeout cycle wins.
        bus.req        = 4'b0010;
        bus.req_filter = 8'h00;
        tick();
        chk("s5_gnt", bus.gnt, 4'b0010);
        bus.req = '0;
        repeat (T + 1) tick();
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        chk("s5_done", bus.job_done, 4'b0010);
        chk("s5_err", bus.job_err, 0);
        chk("s5_jobs", bus.jobs_completed, 6);
        tick();

        // Reset mid-WAIT abandons the job; a late completion is ignored.
        bus.req = 4'b1000;
        tick();
        chk("s6_gnt", bus.gnt, 4'b1000);
        bus.req = '0;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        chk("s6_rst_busy", bus.busy, 0);
        chk("s6_rst_gnt", bus.gnt, 0);
        tick();
        reset_n      = 1'b1;
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("s6_no_resp", {bus.job_done, bus.job_err}, 0);
            tick();
        end
        bus.req = 4'b1111;
        tick();
        chk("s6_next_gnt", bus.gnt, 4'b0001);
        bus.req      = '0;
        bus.eng_done = 1'b1;
        repeat (3) tick();
        bus.eng_done = 1'b0;

        // Randomized traffic with phases of fast, slow and absent engine completions.
        for (int i = 0; i < NR; i++) f[i] = 2'd0;
        p = 40;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: p = 40;
                    1: p = 5;
                    default: p = 0;
                endcase
            end
            if ($urandom_range(0, 3) == 0) bus.req = NR'($urandom_range(0, 15));
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 3) == 0)
                    f[i] = ($urandom_range(0, 3) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                bus.req_filter[2*i +: 2] = f[i];
            end
            bus.eng_done = ($urandom_range(0, 99) < p);
            if ($urandom_range(0, 599) == 0) begin
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end
            tick();
        end
        bus.req      = '0;
        bus.eng_done = 1'b0;
        repeat (T + 6) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
